// File: rtl/if_id_skid_if.sv
// ---------------------------------------------------------------------------
// if_id_skid_if
//
// Bundle of every signal that crosses the IF/ID stage boundary, apart from
// clk and rst.
//
//   Upstream (fetch) side:
//     in_valid, in_instr, in_pc    fetch -> stage
//     in_ready                     stage -> fetch
//   Downstream (decode) side:
//     out_valid, out_instr, out_pc stage -> decode
//     out_rs, out_rt, out_rd       pre-decoded register fields of the head
//     out_branch, out_branch_reg   pre-decoded branch class of the head
//     out_hlt                      head is a valid HLT
//     out_ready                    decode -> stage
//   Control / status:
//     flush                        branch taken, squash all younger entries
//     halted                       sticky halt latch
//     count                        occupancy 0..2
//
// Handshake rule (both sides): a transfer happens on a rising clk edge
// exactly when valid and ready are both 1. A producer holds valid and its
// payload stable until the transfer. in_ready depends on registered state
// only and is never combinational on out_ready.
//
// Modports:
//   slave  - the pipeline stage itself
//   master - the environment around it (fetch + decode + branch unit)
// ---------------------------------------------------------------------------
interface if_id_skid_if #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16
);
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               in_ready;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [3:0]         out_rs;
  logic [3:0]         out_rt;
  logic [3:0]         out_rd;
  logic               out_branch;
  logic               out_branch_reg;
  logic               out_hlt;

  logic               flush;
  logic               halted;
  logic [1:0]         count;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc,
           out_rs, out_rt, out_rd, out_branch, out_branch_reg, out_hlt,
           halted, count
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc,
           out_rs, out_rt, out_rd, out_branch, out_branch_reg, out_hlt,
           halted, count
  );
endinterface

// File: rtl/if_id_skid.sv
// ---------------------------------------------------------------------------
// if_id_skid
//
// IF/ID pipeline stage built as a 2-entry skid buffer with valid/ready on
// both sides, a sticky halt latch, an occupancy count and field pre-decode
// of the head entry.
//
// Parameters:
//   INSTR_W  instruction width (>= 16); opcode is the top 4 bits, register
//            fields are always [11:8], [7:4], [3:0]
//   PC_W     PC width
//   NOP      value shown on out_instr while the head is empty
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   bus      if_id_skid_if.slave, carries both handshakes, flush, the
//            pre-decoded head fields, halted and count
//
// Storage: the head entry is what decode sees; the skid entry only fills
// when the head is stalled and an accept happens in the same cycle. Since
// in_ready = !skid_v, a full skid entry stops fetch one edge later, so the
// ready path to fetch is purely registered.
// ---------------------------------------------------------------------------
module if_id_skid #(
  parameter int                 INSTR_W = 16,
  parameter int                 PC_W    = 16,
  parameter logic [INSTR_W-1:0] NOP     = '0
) (
  input logic         clk,
  input logic         rst,
  if_id_skid_if.slave bus
);

  localparam logic [3:0] OP_HLT = 4'hF;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic               head_v,     head_v_n;
  logic [INSTR_W-1:0] head_instr, head_instr_n;
  logic [PC_W-1:0]    head_pc,    head_pc_n;
  logic               skid_v,     skid_v_n;
  logic [INSTR_W-1:0] skid_instr, skid_instr_n;
  logic [PC_W-1:0]    skid_pc,    skid_pc_n;
  logic               halted_q,   halted_n;

  // -------------------------------------------------------------------------
  // Handshake terms
  // -------------------------------------------------------------------------
  logic       in_ready;
  logic       accept;
  logic       handoff;
  logic [3:0] in_op;
  logic [3:0] head_op;

  assign in_ready = !skid_v && !halted_q;
  assign accept   = bus.in_valid && in_ready;
  assign handoff  = head_v && bus.out_ready;
  assign in_op    = bus.in_instr[INSTR_W-1 -: 4];
  assign head_op  = head_instr[INSTR_W-1 -: 4];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    head_v_n     = head_v;
    head_instr_n = head_instr;
    head_pc_n    = head_pc;
    skid_v_n     = skid_v;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    halted_n     = halted_q;

    if (bus.flush) begin
      // Everything buffered is on the wrong path. Any same-cycle accept is
      // dropped; a same-cycle handoff is the branch itself and is complete.
      head_v_n     = 1'b0;
      skid_v_n     = 1'b0;
      head_instr_n = NOP;
      head_pc_n    = '0;
      skid_instr_n = NOP;
      skid_pc_n    = '0;
      // The halt only survives if the HLT itself is leaving right now, i.e.
      // it was on the correct path.
      halted_n     = halted_q && handoff && (head_op == OP_HLT);
    end else begin
      if (!head_v) begin
        // Empty stage: input lands directly in the head.
        if (accept) begin
          head_v_n     = 1'b1;
          head_instr_n = bus.in_instr;
          head_pc_n    = bus.in_pc;
        end
      end else if (!handoff) begin
        // Head stalled: an accept can only happen with the skid empty,
        // so it parks there.
        if (accept) begin
          skid_v_n     = 1'b1;
          skid_instr_n = bus.in_instr;
          skid_pc_n    = bus.in_pc;
        end
      end else if (skid_v) begin
        // Head leaves and the skid entry moves up. No accept is possible
        // here because in_ready was 0.
        head_instr_n = skid_instr;
        head_pc_n    = skid_pc;
        skid_v_n     = 1'b0;
      end else if (accept) begin
        // Head leaves and is replaced by the new input (streaming case).
        head_instr_n = bus.in_instr;
        head_pc_n    = bus.in_pc;
      end else begin
        head_v_n = 1'b0;
      end

      if (accept && (in_op == OP_HLT)) begin
        halted_n = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_v     <= 1'b0;
      head_instr <= NOP;
      head_pc    <= '0;
      skid_v     <= 1'b0;
      skid_instr <= NOP;
      skid_pc    <= '0;
      halted_q   <= 1'b0;
    end else begin
      head_v     <= head_v_n;
      head_instr <= head_instr_n;
      head_pc    <= head_pc_n;
      skid_v     <= skid_v_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      halted_q   <= halted_n;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [INSTR_W-1:0] out_instr;
  logic [3:0]         out_op;

  // Head fields are masked by head_v so a drained head never shows stale
  // data to decode.
  assign out_instr = head_v ? head_instr : NOP;
  assign out_op    = out_instr[INSTR_W-1 -: 4];

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = head_v;
  assign bus.out_instr      = out_instr;
  assign bus.out_pc         = head_v ? head_pc : '0;
  assign bus.out_rs         = out_instr[7:4];
  assign bus.out_rt         = out_instr[3:0];
  assign bus.out_rd         = out_instr[11:8];
  assign bus.out_branch     = (out_op[3:1] == 3'b110);
  assign bus.out_branch_reg = (out_op == 4'b1101);
  assign bus.out_hlt        = head_v && (out_op == OP_HLT);
  assign bus.halted         = halted_q;
  assign bus.count          = {1'b0, head_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_if_id_skid.sv
// ---------------------------------------------------------------------------
// tb_if_id_skid
//
// Directed sequence plus a short random soak for if_id_skid. A reference
// queue holds {pc, instr} of every buffered entry: entries are pushed on
// accept and popped on handoff, and after every edge all DUT outputs are
// compared against the queue contents and a model halt bit.
// ---------------------------------------------------------------------------
module tb_if_id_skid;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  if_id_skid_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) bus ();

  if_id_skid #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .NOP     (16'h0000)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [PC_W+INSTR_W-1:0] exp_q[$];
  logic                    exp_halted;
  logic                    last_acc;
  int                      errors;
  int                      checks;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_all();
    logic                ev;
    logic [INSTR_W-1:0]  ei;
    logic [PC_W-1:0]     ep;
    ev = (exp_q.size() > 0);
    ei = ev ? exp_q[0][INSTR_W-1:0] : 16'h0000;
    ep = ev ? exp_q[0][PC_W+INSTR_W-1:INSTR_W] : 16'h0000;
    chk("in_ready",       bus.in_ready,       (exp_q.size() < 2) && !exp_halted);
    chk("out_valid",      bus.out_valid,      ev);
    chk("out_instr",      bus.out_instr,      ei);
    chk("out_pc",         bus.out_pc,         ep);
    chk("out_rs",         bus.out_rs,         ei[7:4]);
    chk("out_rt",         bus.out_rt,         ei[3:0]);
    chk("out_rd",         bus.out_rd,         ei[11:8]);
    chk("out_branch",     bus.out_branch,     ei[15:13] == 3'b110);
    chk("out_branch_reg", bus.out_branch_reg, ei[15:12] == 4'b1101);
    chk("out_hlt",        bus.out_hlt,        ev && (ei[15:12] == 4'hF));
    chk("halted",         bus.halted,         exp_halted);
    chk("count",          bus.count,          exp_q.size());
  endtask

  // One clock edge: predict the transfers from the inputs and the model,
  // let the edge happen, then check everything.
  task automatic tick();
    logic                    acc;
    logic                    hnd;
    logic [PC_W+INSTR_W-1:0] front;
    front = '0;
    @(negedge clk);
    acc = bus.in_valid && (exp_q.size() < 2) && !exp_halted;
    hnd = bus.out_ready && (exp_q.size() > 0);
    if (hnd) begin
      front = exp_q.pop_front();
      chk("handoff_pc",    bus.out_pc,    front[PC_W+INSTR_W-1:INSTR_W]);
      chk("handoff_instr", bus.out_instr, front[INSTR_W-1:0]);
    end
    if (bus.flush) begin
      exp_halted = exp_halted && hnd && (front[15:12] == 4'hF);
      exp_q.delete();
      last_acc = 1'b0;
    end else begin
      if (acc) begin
        exp_q.push_back({bus.in_pc, bus.in_instr});
        if (bus.in_instr[15:12] == 4'hF) exp_halted = 1'b1;
      end
      last_acc = acc;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Present one instruction and hold it until it is accepted.
  task automatic send(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] instr);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) return;
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    errors       = 0;
    checks       = 0;
    exp_halted   = 1'b0;
    last_acc     = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc    = '0;
    bus.out_ready = 1'b0;
    bus.flush    = 1'b0;

    // Reset values, both while rst is held and after release.
    @(posedge clk);
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_all();

    // Streaming: PCs 0x0000..0x000E, one per cycle.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom_range(0, 16'hEFFF));
      send(16'(2 * i), ins);
    end
    bus.in_valid = 1'b0;
    tick();
    tick();

    // Backpressure: 0x1234 at head, 0x5678 into skid, 0x9ABC held by fetch.
    bus.out_ready = 1'b0;
    send(16'h0002, 16'h1234);
    send(16'h0004, 16'h5678);
    bus.in_valid = 1'b1;
    bus.in_pc    = 16'h0006;
    bus.in_instr = 16'h9ABC;
    tick();
    chk("bp_held", last_acc, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_skid_to_head", bus.out_instr, 16'h5678);
    tick();
    chk("bp_third", bus.out_instr, 16'h9ABC);
    bus.in_valid = 1'b0;
    tick();
    tick();

    // Flush with count=2 and a same-cycle handoff.
    bus.out_ready = 1'b0;
    send(16'h0010, 16'hC0DE);
    send(16'h0012, 16'h2345);
    bus.in_valid  = 1'b1;
    bus.in_pc     = 16'h0014;
    bus.in_instr  = 16'h3456;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_count", bus.count, 2'd0);
    chk("flush_instr", bus.out_instr, 16'h0000);
    tick();

    // Halt drain: halted sets on accept of 0xF000 and survives its handoff.
    send(16'h0020, 16'h1111);
    send(16'h0022, 16'hF000);
    chk("halt_set", bus.halted, 1'b1);
    chk("halt_out_hlt", bus.out_hlt, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_pc    = 16'h0024;
    bus.in_instr = 16'h2222;
    tick();
    chk("halt_no_accept", last_acc, 1'b0);
    chk("halt_sticky", bus.halted, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("halt_cleared_by_flush", bus.halted, 1'b0);

    // HLT handed off together with a flush: halt stays set.
    bus.out_ready = 1'b0;
    send(16'h0030, 16'hF123);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("halt_kept_on_hlt_handoff", bus.halted, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;

    // Halt squash: HLT in skid behind a branch head, flush with handoff.
    bus.out_ready = 1'b0;
    send(16'h0040, 16'hC123);
    chk("squash_branch", bus.out_branch, 1'b1);
    send(16'h0042, 16'hF000);
    chk("squash_halted_pre", bus.halted, 1'b1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("squash_halted", bus.halted, 1'b0);
    chk("squash_in_ready", bus.in_ready, 1'b1);
    tick();

    // Random soak.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom_range(0, 16'hFFFF));
      if (ins[15:12] == 4'hF && $urandom_range(0, 7) != 0) ins[15] = 1'b0;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = ins;
      bus.in_pc     = 16'($urandom_range(0, 16'hFFFF));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.flush    = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    bus.flush = 1'b0;

    // Async reset mid-cycle with count=2 and halted=1.
    bus.out_ready = 1'b0;
    send(16'h0050, 16'h1111);
    send(16'h0052, 16'hF000);
    bus.in_valid = 1'b0;
    chk("ar_pre_count", bus.count, 2'd2);
    chk("ar_pre_halted", bus.halted, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_halted = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_all();
    bus.out_ready = 1'b1;
    send(16'h0060, 16'h4321);
    bus.in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
